// File: rtl/crypt_pkg.sv
// Shared definitions for the crypt dispatcher slice.
//   OP_*         header[1:0] operation codes
//   MODE_*       tx_mode_out encodings
//   HDR_ERR_BIT  header bit that carries the core-timeout error flag
//   state_t      dispatcher FSM state encoding
package crypt_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ENC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_RT   = 2'b11;

  localparam logic [1:0] MODE_MIXED = 2'b00;
  localparam logic [1:0] MODE_ENC   = 2'b01;
  localparam logic [1:0] MODE_DEC   = 2'b10;

  localparam int HDR_ERR_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC_START,
    ST_ENC_WAIT,
    ST_DEC_START,
    ST_DEC_WAIT,
    ST_OUTPUT
  } state_t;

  // Passthrough reports DEC because both result fields hold plaintext.
  function automatic logic [1:0] op_mode(input logic [1:0] op);
    case (op)
      OP_ENC:  return MODE_ENC;
      OP_RT:   return MODE_MIXED;
      default: return MODE_DEC;
    endcase
  endfunction

endpackage

// File: rtl/crypt_watchdog.sv
// Core-operation watchdog.
//   clk_in, rst_in  clock, synchronous active-low reset
//   clear           restart the count from zero
//   enable          count one waited cycle
//   expired         high on the TIMEOUT_CYCLES-th enabled cycle after clear
module crypt_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_in) begin
    if (!rst_in)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + CW'(1);
  end

  // The count holds 0..TIMEOUT_CYCLES-1 across the wait cycles, so the
  // terminal value marks the last permitted wait cycle.
  assign expired = (count == TERMINAL);

endmodule

// File: rtl/crypt_dispatcher.sv
// Dispatches received messages through a cipher core and presents the
// encrypted/decrypted pair with an echoed header.
//   clk_in, rst_in        clock, synchronous active-low reset
//   rx_*                  message intake (valid/ready, header op in [1:0])
//   core_*                cipher core start/done handshake and operands
//   tx_*                  result bundle (valid/ready, fields, mode)
//   busy_out              job in progress
//   timeout_count_out     saturating count of core timeouts
//
// state        | meaning
// -------------+-------------------------------------------------
// ST_IDLE      | waiting for a message, rx_ready_out high
// ST_ENC_START | one-cycle encrypt start pulse, watchdog cleared
// ST_ENC_WAIT  | waiting for core_done_in on the encrypt pass
// ST_DEC_START | one-cycle decrypt start pulse, watchdog cleared
// ST_DEC_WAIT  | waiting for core_done_in on the decrypt pass
// ST_OUTPUT    | tx bundle held valid until tx_ready_in
module crypt_dispatcher
  import crypt_pkg::*;
#(
  parameter int MESSAGE_SIZE   = 512,
  parameter int HEADER_SIZE    = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rx_valid_in,
  output logic                    rx_ready_out,
  input  logic [MESSAGE_SIZE-1:0] rx_message_in,
  input  logic [HEADER_SIZE-1:0]  rx_header_in,
  output logic                    core_start_out,
  output logic                    core_decrypt_out,
  output logic [MESSAGE_SIZE-1:0] core_data_out,
  input  logic                    core_done_in,
  input  logic [MESSAGE_SIZE-1:0] core_data_in,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic [MESSAGE_SIZE-1:0] tx_encrypted_out,
  output logic [MESSAGE_SIZE-1:0] tx_decrypted_out,
  output logic [HEADER_SIZE-1:0]  tx_header_out,
  output logic [1:0]              tx_mode_out,
  output logic                    busy_out,
  output logic [7:0]              timeout_count_out
);

  state_t state, state_n;

  logic [HEADER_SIZE-1:0]  hdr_q;
  logic [MESSAGE_SIZE-1:0] enc_q, dec_q, core_data_q;
  logic [1:0]              mode_q;
  logic                    err_q;
  logic [7:0]              tocnt_q;

  logic accept, done_hit, timeout_hit, wd_clear, wd_enable, wd_expired;

  crypt_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // Done is checked before expiry so a coincident done wins.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid_in) begin
          accept = 1'b1;
          case (rx_header_in[1:0])
            OP_PASS: state_n = ST_OUTPUT;
            OP_DEC:  state_n = ST_DEC_START;
            default: state_n = ST_ENC_START;
          endcase
        end
      end
      ST_ENC_START: begin
        wd_clear = 1'b1;
        state_n  = ST_ENC_WAIT;
      end
      ST_ENC_WAIT: begin
        wd_enable = 1'b1;
        if (core_done_in) begin
          done_hit = 1'b1;
          state_n  = (hdr_q[1:0] == OP_RT) ? ST_DEC_START : ST_OUTPUT;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_n     = ST_OUTPUT;
        end
      end
      ST_DEC_START: begin
        wd_clear = 1'b1;
        state_n  = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        wd_enable = 1'b1;
        if (core_done_in) begin
          done_hit = 1'b1;
          state_n  = ST_OUTPUT;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_n     = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (tx_ready_in)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Both result fields start as the input so a timed-out pass leaves its
  // field equal to the input. The encrypt result also becomes the core
  // operand for the decrypt pass of a round-trip.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hdr_q       <= '0;
      enc_q       <= '0;
      dec_q       <= '0;
      core_data_q <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      tocnt_q     <= '0;
    end else begin
      if (accept) begin
        hdr_q       <= rx_header_in;
        enc_q       <= rx_message_in;
        dec_q       <= rx_message_in;
        core_data_q <= rx_message_in;
        mode_q      <= op_mode(rx_header_in[1:0]);
        err_q       <= 1'b0;
      end
      if (done_hit) begin
        if (state == ST_ENC_WAIT) begin
          enc_q       <= core_data_in;
          core_data_q <= core_data_in;
        end else begin
          dec_q <= core_data_in;
        end
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
        if (tocnt_q != 8'hFF)
          tocnt_q <= tocnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    tx_header_out              = hdr_q;
    tx_header_out[HDR_ERR_BIT] = hdr_q[HDR_ERR_BIT] | err_q;
  end

  assign rx_ready_out      = (state == ST_IDLE);
  assign busy_out          = (state != ST_IDLE);
  assign core_start_out    = (state == ST_ENC_START) || (state == ST_DEC_START);
  assign core_decrypt_out  = (state == ST_DEC_START) || (state == ST_DEC_WAIT);
  assign core_data_out     = core_data_q;
  assign tx_valid_out      = (state == ST_OUTPUT);
  assign tx_encrypted_out  = enc_q;
  assign tx_decrypted_out  = dec_q;
  assign tx_mode_out       = mode_q;
  assign timeout_count_out = tocnt_q;

endmodule

// File: tb/tb_crypt_dispatcher.sv
// Directed self-checking bench for crypt_dispatcher (64-bit payload,
// 32-bit header, 16-cycle watchdog).
module tb_crypt_dispatcher;

  localparam int MS = 64;
  localparam int HS = 32;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rx_valid_in;
  logic          rx_ready_out;
  logic [MS-1:0] rx_message_in;
  logic [HS-1:0] rx_header_in;
  logic          core_start_out;
  logic          core_decrypt_out;
  logic [MS-1:0] core_data_out;
  logic          core_done_in;
  logic [MS-1:0] core_data_in;
  logic          tx_valid_out;
  logic          tx_ready_in;
  logic [MS-1:0] tx_encrypted_out;
  logic [MS-1:0] tx_decrypted_out;
  logic [HS-1:0] tx_header_out;
  logic [1:0]    tx_mode_out;
  logic          busy_out;
  logic [7:0]    timeout_count_out;

  crypt_dispatcher #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rx_valid_in       (rx_valid_in),
    .rx_ready_out      (rx_ready_out),
    .rx_message_in     (rx_message_in),
    .rx_header_in      (rx_header_in),
    .core_start_out    (core_start_out),
    .core_decrypt_out  (core_decrypt_out),
    .core_data_out     (core_data_out),
    .core_done_in      (core_done_in),
    .core_data_in      (core_data_in),
    .tx_valid_out      (tx_valid_out),
    .tx_ready_in       (tx_ready_in),
    .tx_encrypted_out  (tx_encrypted_out),
    .tx_decrypted_out  (tx_decrypted_out),
    .tx_header_out     (tx_header_out),
    .tx_mode_out       (tx_mode_out),
    .busy_out          (busy_out),
    .timeout_count_out (timeout_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [MS-1:0] PAT_A5 = {8{8'hA5}};
  localparam logic [MS-1:0] PAT_12 = {4{16'h1234}};
  localparam logic [MS-1:0] M1     = 64'h0123_4567_89AB_CDEF;
  localparam logic [MS-1:0] M2     = 64'hDEAD_BEEF_0F1E_2D3C;
  localparam logic [MS-1:0] M3     = 64'h5566_7788_99AA_BBCC;
  localparam logic [MS-1:0] R2     = 64'hCAFE_F00D_1357_9BDF;
  localparam logic [MS-1:0] ALL_FF = {8{8'hFF}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Op 10 job with no core_done: 1 cycle DEC_START, 16 wait cycles, OUTPUT,
  // then the handshake back to IDLE.
  task automatic timeout_job();
    rx_header_in  = 32'h0000_00F2;
    rx_message_in = M3;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    repeat (TO + 1) step();
    step();
  endtask

  int starts;
  int bad;

  initial begin
    rst_in        = 1'b0;
    rx_valid_in   = 1'b0;
    rx_message_in = '0;
    rx_header_in  = '0;
    core_done_in  = 1'b0;
    core_data_in  = '0;
    tx_ready_in   = 1'b1;
    step();
    step();
    check("rst_rx_ready", 64'(rx_ready_out), 64'(1));
    check("rst_tx_valid", 64'(tx_valid_out), 64'(0));
    check("rst_busy", 64'(busy_out), 64'(0));
    check("rst_start", 64'(core_start_out), 64'(0));
    check("rst_tocnt", 64'(timeout_count_out), 64'(0));
    check("rst_hdr", 64'(tx_header_out), 64'(0));
    rst_in = 1'b1;
    step();

    // Passthrough
    rx_header_in  = 32'h0000_1230;
    rx_message_in = PAT_A5;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    check("pt_valid", 64'(tx_valid_out), 64'(1));
    check("pt_enc", tx_encrypted_out, PAT_A5);
    check("pt_dec", tx_decrypted_out, PAT_A5);
    check("pt_mode", 64'(tx_mode_out), 64'(2'b10));
    check("pt_hdr", 64'(tx_header_out), 64'h0000_1230);
    check("pt_rx_ready", 64'(rx_ready_out), 64'(0));
    step();
    check("pt_ret_valid", 64'(tx_valid_out), 64'(0));
    check("pt_ret_ready", 64'(rx_ready_out), 64'(1));

    // Encrypt, done on the 10th wait cycle
    rx_header_in  = 32'h0000_ABC1;
    rx_message_in = M1;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    check("enc_start", 64'(core_start_out), 64'(1));
    check("enc_decflag", 64'(core_decrypt_out), 64'(0));
    check("enc_operand", core_data_out, M1);
    starts = 0;
    bad    = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (core_start_out) starts++;
      if (core_data_out !== M1 || core_decrypt_out !== 1'b0 || tx_valid_out !== 1'b0) bad++;
    end
    check("enc_wait_stable", 64'(bad), 64'(0));
    core_done_in = 1'b1;
    core_data_in = PAT_12;
    step();
    core_done_in = 1'b0;
    check("enc_extra_starts", 64'(starts), 64'(0));
    check("enc_valid", 64'(tx_valid_out), 64'(1));
    check("enc_enc", tx_encrypted_out, PAT_12);
    check("enc_dec", tx_decrypted_out, M1);
    check("enc_mode", 64'(tx_mode_out), 64'(2'b01));
    check("enc_hdr", 64'(tx_header_out), 64'h0000_ABC1);
    step();

    // Round-trip with an XOR-0xFF core
    rx_header_in  = 32'h0000_0003;
    rx_message_in = M2;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    check("rt_start1", 64'(core_start_out), 64'(1));
    check("rt_decflag1", 64'(core_decrypt_out), 64'(0));
    step();
    core_done_in = 1'b1;
    core_data_in = M2 ^ ALL_FF;
    step();
    core_done_in = 1'b0;
    check("rt_start2", 64'(core_start_out), 64'(1));
    check("rt_decflag2", 64'(core_decrypt_out), 64'(1));
    check("rt_operand2", core_data_out, M2 ^ ALL_FF);
    step();
    core_done_in = 1'b1;
    core_data_in = (M2 ^ ALL_FF) ^ ALL_FF;
    step();
    core_done_in = 1'b0;
    check("rt_valid", 64'(tx_valid_out), 64'(1));
    check("rt_enc", tx_encrypted_out, M2 ^ ALL_FF);
    check("rt_dec", tx_decrypted_out, M2);
    check("rt_mode", 64'(tx_mode_out), 64'(2'b00));
    check("rt_hdr", 64'(tx_header_out), 64'h0000_0003);
    step();

    // Decrypt with no done: timeout after 16 wait cycles
    rx_header_in  = 32'h0000_00F2;
    rx_message_in = M3;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    check("to_decflag", 64'(core_decrypt_out), 64'(1));
    repeat (TO) step();
    check("to_not_yet", 64'(tx_valid_out), 64'(0));
    step();
    check("to_valid", 64'(tx_valid_out), 64'(1));
    check("to_hdr", 64'(tx_header_out), 64'h0000_00F6);
    check("to_enc", tx_encrypted_out, M3);
    check("to_dec", tx_decrypted_out, M3);
    check("to_mode", 64'(tx_mode_out), 64'(2'b10));
    check("to_count1", 64'(timeout_count_out), 64'(1));
    step();

    // Done coinciding with expiry: done wins
    rx_header_in  = 32'h0000_00F2;
    rx_message_in = M3;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    repeat (TO) step();
    core_done_in = 1'b1;
    core_data_in = R2;
    step();
    core_done_in = 1'b0;
    check("race_valid", 64'(tx_valid_out), 64'(1));
    check("race_hdr", 64'(tx_header_out), 64'h0000_00F2);
    check("race_dec", tx_decrypted_out, R2);
    check("race_count", 64'(timeout_count_out), 64'(1));
    step();

    // 299 more timeouts: count saturates at 255
    for (int i = 2; i <= 300; i++) begin
      timeout_job();
      if (i == 254) check("sat_254", 64'(timeout_count_out), 64'(254));
      if (i == 255) check("sat_255", 64'(timeout_count_out), 64'(255));
    end
    check("sat_300", 64'(timeout_count_out), 64'(255));

    // Back-pressure: hold OUTPUT for 50 cycles
    tx_ready_in   = 1'b0;
    rx_header_in  = 32'h0000_5550;
    rx_message_in = PAT_A5;
    rx_valid_in   = 1'b1;
    step();
    rx_message_in = M1;
    rx_header_in  = 32'h0000_0001;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid_out !== 1'b1 || rx_ready_out !== 1'b0 ||
          tx_encrypted_out !== PAT_A5 || tx_decrypted_out !== PAT_A5 ||
          tx_header_out !== 32'h0000_5550 || tx_mode_out !== 2'b10) bad++;
      step();
    end
    rx_valid_in = 1'b0;
    check("stall_stable", 64'(bad), 64'(0));
    check("stall_still_valid", 64'(tx_valid_out), 64'(1));
    tx_ready_in = 1'b1;
    step();
    check("stall_release_ready", 64'(rx_ready_out), 64'(1));
    check("stall_release_valid", 64'(tx_valid_out), 64'(0));

    // Reset during ENC_WAIT, then a stray done
    rx_header_in  = 32'h0000_0001;
    rx_message_in = M1;
    rx_valid_in   = 1'b1;
    step();
    rx_valid_in = 1'b0;
    repeat (3) step();
    check("abort_busy_pre", 64'(busy_out), 64'(1));
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("abort_idle", 64'(rx_ready_out), 64'(1));
    check("abort_tocnt", 64'(timeout_count_out), 64'(0));
    check("abort_hdr", 64'(tx_header_out), 64'(0));
    core_done_in = 1'b1;
    core_data_in = PAT_12;
    step();
    core_done_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid_out !== 1'b0 || busy_out !== 1'b0 || core_start_out !== 1'b0) bad++;
      step();
    end
    check("abort_stray_done", 64'(bad), 64'(0));
    check("abort_enc_field", tx_encrypted_out, 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
